demux_1to8: RTL and testbench

- Registered 1-to-8 demultiplexer.
- Routes a WIDTH-bit input word onto one of eight output lanes selected by a 3-bit select; all other lanes are driven to zero.
- Sits between a single-source producer and eight lane consumers. Outputs are registered with one clock of latency, so lane outputs are glitch-free.

---
 rtl/demux_1to8_if.sv | 24 ++
 rtl/demux_1to8.sv | 38 +++
 tb/tb_demux_1to8.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/demux_1to8_if.sv
// Bus bundle for the 1-to-8 demultiplexer: producer-side input word and select,
// plus the registered lane outputs seen by the consumers.
interface demux_1to8_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0]   in;
  logic [2:0]         sel;
  logic               en;
  logic [8*WIDTH-1:0] out;
  logic [7:0]         lane_onehot;
  logic               out_valid;

  // producer / testbench side
  modport master (
    output in, sel, en,
    input  out, lane_onehot, out_valid
  );

  // demultiplexer side
  modport slave (
    input  in, sel, en,
    output out, lane_onehot, out_valid
  );
endinterface

// File: rtl/demux_1to8.sv
// Registered 1-to-8 demultiplexer. The selected lane carries the input word one
// clock after it is sampled; all other lanes are zero. Everything leaving the
// block comes straight from flops, so lanes are glitch-free.
module demux_1to8 #(
  parameter int WIDTH = 1
) (
  input logic         clk,
  input logic         rst_n,
  demux_1to8_if.slave bus
);

  logic [8*WIDTH-1:0] out_nxt;
  logic [7:0]         onehot_nxt;

  // Next-cycle lane image: only the selected lane may be nonzero, and only when enabled.
  always_comb begin
    out_nxt    = '0;
    onehot_nxt = 8'h00;
    if (bus.en) begin
      out_nxt[bus.sel*WIDTH +: WIDTH] = bus.in;
      onehot_nxt                      = 8'h01 << bus.sel;
    end
  end

  // Output registers; a disabled cycle clears the route rather than holding it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out         <= '0;
      bus.lane_onehot <= 8'h00;
      bus.out_valid   <= 1'b0;
    end else begin
      bus.out         <= out_nxt;
      bus.lane_onehot <= onehot_nxt;
      bus.out_valid   <= bus.en;
    end
  end

endmodule

// File: tb/tb_demux_1to8.sv
// Bench for demux_1to8: runs a WIDTH=1 and a WIDTH=4 instance side by side from
// the same select/enable stream and compares against a scoreboard of expected
// lane images pushed when stimulus is applied.
module tb_demux_1to8;

  logic clk;
  logic rst_n;

  demux_1to8_if #(.WIDTH(1)) b1 ();
  demux_1to8_if #(.WIDTH(4)) b4 ();

  demux_1to8 #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  demux_1to8 #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  typedef struct {
    logic [7:0]  o1;
    logic [31:0] o4;
    logic [7:0]  oh;
    logic        v;
  } exp_t;

  exp_t sb[$];
  exp_t x;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus to both instances and queue what should appear
  // on the outputs after the next rising edge.
  task automatic drive(input logic e, input logic [2:0] s, input logic i1, input logic [3:0] i4);
    exp_t t;
    b1.en = e;  b1.sel = s; b1.in = i1;
    b4.en = e;  b4.sel = s; b4.in = i4;
    t.o1 = e ? (8'({7'd0, i1}) << s) : 8'h00;
    t.o4 = e ? (32'({28'd0, i4}) << {s, 2'b00}) : 32'h0;
    t.oh = e ? (8'h01 << s) : 8'h00;
    t.v  = e;
    sb.push_back(t);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 3'd3, 1'b1, 4'hF);
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({b1.out, b4.out, b1.lane_onehot, b4.lane_onehot, b1.out_valid, b4.out_valid} !== 66'h0) begin
        errors++;
        $display("FAIL reset cyc%0d: out1=%h out4=%h oh1=%h oh4=%h v=%b%b required all zero",
                 i, b1.out, b4.out, b1.lane_onehot, b4.lane_onehot, b1.out_valid, b4.out_valid);
      end
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_lane_sweep();
    for (int s = 0; s < 8; s++) begin
      drive(1'b1, 3'(s), 1'b1, 4'(s + 1));
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sweep sel%0d: scoreboard empty", s);
      end else begin
        x = sb.pop_front();
        if ({b1.out, b4.out, b1.lane_onehot, b4.lane_onehot, b1.out_valid, b4.out_valid} !== {x.o1, x.o4, x.oh, x.oh, x.v, x.v}) begin
          errors++;
          $display("FAIL sweep sel%0d: out1=%h out4=%h oh=%h/%h v=%b%b required out1=%h out4=%h oh=%h v=%b",
                   s, b1.out, b4.out, b1.lane_onehot, b4.lane_onehot, b1.out_valid, b4.out_valid, x.o1, x.o4, x.oh, x.v);
        end
      end
    end
  endtask

  task automatic test_zero_data();
    drive(1'b1, 3'd5, 1'b0, 4'h0);
    @(posedge clk); #1;
    checks++;
    x = sb.pop_front();
    if ({b1.out, b4.out, b1.lane_onehot, b4.lane_onehot, b1.out_valid, b4.out_valid} !== {x.o1, x.o4, x.oh, x.oh, x.v, x.v}
        || b1.lane_onehot !== 8'b0010_0000) begin
      errors++;
      $display("FAIL zero_data: out1=%h out4=%h oh=%h v=%b required out=0 oh=20 v=1",
               b1.out, b4.out, b1.lane_onehot, b1.out_valid);
    end
  endtask

  task automatic test_enable_gating();
    drive(1'b1, 3'd2, 1'b1, 4'h5);
    @(posedge clk); #1;
    drive(1'b0, 3'd2, 1'b1, 4'h5);
    for (int i = 0; i < 2; i++) begin
      checks++;
      x = sb.pop_front();
      if ({b1.out, b4.out, b1.lane_onehot, b4.lane_onehot, b1.out_valid, b4.out_valid} !== {x.o1, x.o4, x.oh, x.oh, x.v, x.v}) begin
        errors++;
        $display("FAIL enable_gating step%0d: out1=%h out4=%h oh=%h v=%b required out1=%h out4=%h oh=%h v=%b",
                 i, b1.out, b4.out, b1.lane_onehot, b1.out_valid, x.o1, x.o4, x.oh, x.v);
      end
      if (i == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 3'd7, 1'b1, 4'h9);
    @(posedge clk); #1;
    checks++;
    x = sb.pop_front();
    if (b1.out !== x.o1 || b4.out !== x.o4) begin
      errors++;
      $display("FAIL async_pre: out1=%h out4=%h required %h %h", b1.out, b4.out, x.o1, x.o4);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({b1.out, b4.out, b1.lane_onehot, b4.lane_onehot, b1.out_valid, b4.out_valid} !== 66'h0) begin
      errors++;
      $display("FAIL async_clear: out1=%h out4=%h oh=%h v=%b required all zero",
               b1.out, b4.out, b1.lane_onehot, b1.out_valid);
    end
    sb.delete();
    #1 rst_n = 1'b1;
    drive(1'b1, 3'd1, 1'b1, 4'h3);
    @(posedge clk); #1;
    checks++;
    x = sb.pop_front();
    if ({b1.out, b4.out, b1.lane_onehot, b1.out_valid} !== {x.o1, x.o4, x.oh, x.v} || b1.out !== 8'h02) begin
      errors++;
      $display("FAIL async_release: out1=%h out4=%h oh=%h v=%b required out1=02 out4=%h oh=%h v=1",
               b1.out, b4.out, b1.lane_onehot, b1.out_valid, x.o4, x.oh);
    end
  endtask

  task automatic test_wide();
    drive(1'b1, 3'd6, 1'b1, 4'hA);
    @(posedge clk); #1;
    checks++;
    x = sb.pop_front();
    if (b4.out !== 32'h0A00_0000 || b4.out !== x.o4 || b4.lane_onehot !== 8'b0100_0000 || b4.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wide: out4=%h oh=%h v=%b required out4=0a000000 oh=40 v=1",
               b4.out, b4.lane_onehot, b4.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      @(posedge clk); #1;
      checks++;
      x = sb.pop_front();
      if ({b1.out, b4.out, b1.lane_onehot, b4.lane_onehot, b1.out_valid, b4.out_valid} !== {x.o1, x.o4, x.oh, x.oh, x.v, x.v}) begin
        errors++;
        $display("FAIL b2b%0d: out1=%h out4=%h oh=%h/%h v=%b%b required out1=%h out4=%h oh=%h v=%b",
                 i, b1.out, b4.out, b1.lane_onehot, b4.lane_onehot, b1.out_valid, b4.out_valid, x.o1, x.o4, x.oh, x.v);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    b1.en = 1'b0; b1.sel = 3'd0; b1.in = '0;
    b4.en = 1'b0; b4.sel = 3'd0; b4.in = '0;
    test_reset();
    test_lane_sweep();
    test_zero_data();
    test_enable_gating();
    test_async_reset();
    test_wide();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
